// File: rtl/nibble_op_reg.sv
// WIDTH-bit datapath register with load, shift, increment/decrement and shadow
// save/restore; registered carry/borrow/shift-out flag and combinational zero flag.
module nibble_op_reg #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] D,
   input  logic             ser_in,
   output logic [WIDTH-1:0] Q,
   output logic             carry,
   output logic             zero
);

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_LOAD    = 3'b001,
      OP_SHL     = 3'b010,
      OP_SHR     = 3'b011,
      OP_INC     = 3'b100,
      OP_DEC     = 3'b101,
      OP_SAVE    = 3'b110,
      OP_RESTORE = 3'b111
   } op_e;

   localparam logic [WIDTH:0]   INC_ONE = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] DEC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   op_e              op_sel;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             carry_q, carry_d;
   logic [WIDTH:0]   inc_sum;

   assign op_sel  = op_e'(op);
   // Increment at WIDTH+1 bits so the MSB is the wrap-around carry.
   assign inc_sum = {1'b0, q_q} + INC_ONE;

   always_comb begin
      q_d      = q_q;
      carry_d  = carry_q;
      shadow_d = shadow_q;
      if (enable) begin
         case (op_sel)
            OP_NOP: ;
            OP_LOAD: begin
               q_d     = D;
               carry_d = 1'b0;
            end
            OP_SHL: begin
               q_d     = {q_q[WIDTH-2:0], ser_in};
               carry_d = q_q[WIDTH-1];
            end
            OP_SHR: begin
               q_d     = {ser_in, q_q[WIDTH-1:1]};
               carry_d = q_q[0];
            end
            OP_INC: begin
               q_d     = inc_sum[WIDTH-1:0];
               carry_d = inc_sum[WIDTH];
            end
            OP_DEC: begin
               q_d     = q_q - DEC_ONE;
               carry_d = (q_q == '0);
            end
            OP_SAVE: shadow_d = q_q;
            OP_RESTORE: begin
               q_d     = shadow_q;
               carry_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q      <= RESET_VAL;
         carry_q  <= 1'b0;
         shadow_q <= RESET_VAL;
      end else begin
         q_q      <= q_d;
         carry_q  <= carry_d;
         shadow_q <= shadow_d;
      end
   end

   assign Q     = q_q;
   assign carry = carry_q;
   assign zero  = (q_q == '0);

endmodule
